// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined N-bit carry-lookahead adder/subtractor with valid/ready handshake.
// Optional OVF/ZERO flag logic is enabled by defining CLA_ADDSUB_FLAGS_EN.
module cla_addsub_pipe #(
  parameter int unsigned N = 8
) (
  input  logic         PHI,
  input  logic         RST_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] OPA,
  input  logic [N-1:0] OPB,
  input  logic         CIN,
  input  logic         SUB,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         OVF,
  output logic         ZERO
);

  localparam int unsigned LO = N / 2;
  localparam int unsigned HI = N - LO;

  // Flat lookahead: each carry is formed from the group generate/propagate of
  // all lower bits and the carry-in, rather than rippling bit to bit.
  function automatic logic [LO:0] cla_add(input logic [LO-1:0] a,
                                          input logic [LO-1:0] b,
                                          input logic          ci);
    logic [LO-1:0] g;
    logic [LO-1:0] p;
    logic [LO-1:0] s;
    logic [LO:0]   c;
    logic          acc_g;
    logic          acc_p;
    g    = a & b;
    p    = a ^ b;
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < LO; i++) begin
      acc_g = 1'b0;
      acc_p = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        acc_g = g[j] | (p[j] & acc_g);
        acc_p = acc_p & p[j];
      end
      c[i+1] = acc_g | (acc_p & ci);
      s[i]   = p[i] ^ c[i];
    end
    return {c[LO], s};
  endfunction

  logic          adv1;
  logic          adv2;
  logic          s1_valid;
  logic          s2_valid;
  logic [LO-1:0] s1_lo;
  logic          s1_c;
  logic [HI-1:0] s1_a_hi;
  logic [HI-1:0] s1_b_hi;
  logic          s1_sub;

  logic [N-1:0]  b_eff;
  logic          c0;
  logic [LO:0]   lo_res;
  logic [HI:0]   hi_res;
  logic [HI-1:0] hi_sum;
  logic          c_n;
  logic [N-1:0]  sum_next;

  assign adv2      = ~s2_valid | OUT_READY;
  assign adv1      = ~s1_valid | adv2;
  assign IN_READY  = adv1;
  assign OUT_VALID = s2_valid;

  // Subtraction is folded into addition as A + ~B + ~borrow_in.
  always_comb begin
    b_eff  = SUB ? ~OPB : OPB;
    c0     = CIN ^ SUB;
    lo_res = cla_add(OPA[LO-1:0], b_eff[LO-1:0], c0);
  end

  always_comb begin
    hi_res   = cla_add(s1_a_hi, s1_b_hi, s1_c);
    hi_sum   = hi_res[HI-1:0];
    c_n      = hi_res[HI];
    sum_next = {hi_sum, s1_lo};
  end

  always_ff @(posedge PHI or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_sub   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_lo   <= lo_res[LO-1:0];
        s1_c    <= lo_res[LO];
        s1_a_hi <= OPA[N-1:LO];
        s1_b_hi <= b_eff[N-1:LO];
        s1_sub  <= SUB;
      end
    end
  end

  always_ff @(posedge PHI or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid <= 1'b0;
      SUM      <= '0;
      COUT     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        SUM  <= sum_next;
        COUT <= c_n ^ s1_sub;
      end
    end
  end

`ifdef CLA_ADDSUB_FLAGS_EN
  logic ovf_next;

  // Sign bits of A and B' are the top bits of the registered high halves.
  always_comb begin
    ovf_next = (s1_a_hi[HI-1] == s1_b_hi[HI-1]) && (hi_sum[HI-1] != s1_a_hi[HI-1]);
  end

  always_ff @(posedge PHI or negedge RST_N) begin
    if (!RST_N) begin
      OVF  <= 1'b0;
      ZERO <= 1'b0;
    end else if (adv2 && s1_valid) begin
      OVF  <= ovf_next;
      ZERO <= ~|sum_next;
    end
  end
`else
  assign OVF  = 1'b0;
  assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed cases, backpressure, mid-flight
// reset and a random stream scored against an arithmetic reference model.
module tb_cla_addsub_pipe;

  localparam int unsigned N = 8;
`ifdef CLA_ADDSUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic         PHI       = 1'b0;
  logic         RST_N     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [N-1:0] opa       = '0;
  logic [N-1:0] opb       = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  cla_addsub_pipe #(.N(N)) dut (
    .PHI       (PHI),
    .RST_N     (RST_N),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OPA       (opa),
    .OPB       (opb),
    .CIN       (cin),
    .SUB       (sub),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SUM       (sum),
    .COUT      (cout),
    .OVF       (ovf),
    .ZERO      (zero)
  );

  always #5 PHI = ~PHI;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         s;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  res_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pushed     = 0;
  int   popped     = 0;
  bit   last_in_fire;
  bit   last_out_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, independent of the pipeline.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic ci, input logic s);
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   ur;
    int   sr;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      ur     = ua + ub + int'(ci);
      sr     = sa + sb + int'(ci);
      r.cout = (ur >= (1 << N));
    end else begin
      ur     = ua - ub - int'(ci);
      sr     = sa - sb - int'(ci);
      r.cout = (ur < 0);
    end
    r.sum  = ur[N-1:0];
    r.ovf  = FLAGS_ON && ((sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1))));
    r.zero = FLAGS_ON && (r.sum == '0);
    return r;
  endfunction

  task automatic set_beat(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic ci, input logic s);
    opa = a;
    opb = b;
    cin = ci;
    sub = s;
  endtask

  // One clock: sample handshakes at the falling edge, score any output transfer,
  // record any input transfer, then return 1 time unit after the rising edge.
  task automatic tick();
    res_t e;
    @(negedge PHI);
    last_in_fire  = in_valid && in_ready;
    last_out_fire = out_valid && out_ready;
    if (last_out_fire) begin
      if (exp_q.size() == 0) begin
        check("stray_out", 32'(out_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        popped++;
        check("sum",  32'(sum),  32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf",  32'(ovf),  32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
      end
    end
    if (last_in_fire) begin
      exp_q.push_back(model(opa, opb, cin, sub));
      pushed++;
    end
    @(posedge PHI);
    #1;
  endtask

  vec_t         vecs[5];
  logic [N-1:0] bp_a[4];
  logic [N-1:0] bp_b[4];
  logic [N-1:0] held_sum;
  logic         held_cout;
  int           idx;
  int           pop_base;
  int           sent;
  int           cycles;

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    bp_a    = '{8'h11, 8'h42, 8'h93, 8'hC4};
    bp_b    = '{8'h05, 8'h37, 8'h2A, 8'h6F};

    // Asynchronous reset state
    #1 RST_N = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_sum",       32'(sum),       32'(8'h00));
    check("rst_cout",      32'(cout),      32'(1'b0));
    check("rst_ovf",       32'(ovf),       32'(1'b0));
    check("rst_zero",      32'(zero),      32'(1'b0));
    #10 RST_N = 1'b1;
    @(posedge PHI);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1'b1));

    // ADD latency: 0x7F + 0x01
    set_beat(8'h7F, 8'h01, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    check("lat_accept", 32'(last_in_fire), 32'(1'b1));
    check("lat_k_valid", 32'(out_valid), 32'(1'b0));
    in_valid = 1'b0;
    tick();
    check("lat_k1_valid", 32'(out_valid), 32'(1'b1));
    check("lat_sum",      32'(sum),       32'(8'h80));
    check("lat_cout",     32'(cout),      32'(1'b0));
    check("lat_ovf",      32'(ovf),       32'(FLAGS_ON));
    check("lat_zero",     32'(zero),      32'(1'b0));
    tick();

    // Wrap-around and subtract/borrow vectors
    for (int v = 0; v < 5; v++) begin
      set_beat(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].s);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("vec_valid", 32'(out_valid), 32'(1'b1));
      check("vec_sum",   32'(sum),       32'(vecs[v].sum));
      check("vec_cout",  32'(cout),      32'(vecs[v].cout));
      check("vec_ovf",   32'(ovf),       32'(vecs[v].ovf & FLAGS_ON));
      check("vec_zero",  32'(zero),      32'(vecs[v].zero & FLAGS_ON));
      tick();
    end

    // Backpressure: 4 beats offered while the consumer stalls
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      set_beat(bp_a[idx], bp_b[idx], 1'b0, c[0]);
      in_valid = 1'b1;
      tick();
      if (last_in_fire) idx++;
      if (c >= 1) begin
        check("bp_in_ready", 32'(in_ready), 32'(1'b0));
        check("bp_out_valid", 32'(out_valid), 32'(1'b1));
      end
      if (c == 1) begin
        held_sum  = sum;
        held_cout = cout;
      end
      if (c >= 2) begin
        check("bp_hold_sum",  32'(sum),  32'(held_sum));
        check("bp_hold_cout", 32'(cout), 32'(held_cout));
      end
    end
    check("bp_accepts", 32'(idx), 32'(2));
    out_ready = 1'b1;
    pop_base  = popped;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin
        set_beat(bp_a[idx], bp_b[idx], 1'b0, idx[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check("bp_stream_valid", 32'(out_valid), 32'(1'b1));
      tick();
      if (last_in_fire) idx++;
    end
    in_valid = 1'b0;
    check("bp_drained", 32'(popped - pop_base), 32'(4));

    // Reset with two beats in flight
    out_ready = 1'b0;
    set_beat(8'h3C, 8'h0F, 1'b1, 1'b0);
    in_valid = 1'b1;
    tick();
    set_beat(8'hA5, 8'h5A, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mid_full", 32'(out_valid), 32'(1'b1));
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(1'b0));
    check("mid_rst_sum",   32'(sum),       32'(8'h00));
    pushed -= exp_q.size();
    exp_q.delete();
    @(negedge PHI);
    #1 RST_N = 1'b1;
    @(posedge PHI);
    #1;
    check("mid_in_ready", 32'(in_ready), 32'(1'b1));
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_no_stale", 32'(out_valid), 32'(1'b0));
    end

    // Random stream of 1000 beats with random valid/ready
    sent   = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      set_beat(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      if (last_in_fire) sent++;
      cycles++;
    end
    check("rand_sent", 32'(sent), 32'(1000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      tick();
    end
    check("rand_drain_empty", 32'(exp_q.size()), 32'(0));
    check("rand_conservation", 32'(popped), 32'(pushed));
    check("rand_idle_valid", 32'(out_valid), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
